// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, flit width and the output-arbiter state encoding.
package noc_pkg;

  localparam int unsigned LOCAL  = 0;
  localparam int unsigned NORTH  = 1;
  localparam int unsigned EAST   = 2;
  localparam int unsigned SOUTH  = 3;
  localparam int unsigned WEST   = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StCap  = 2'd2,
    StSend = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NUM_IN.
module rr_pick #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              any_req
);

  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      if (!any_req && req[(32'(ptr) + k) % NUM_IN]) begin
        idx     = IDX_W'((32'(ptr) + k) % NUM_IN);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin scheduler for one router output: reads a granted input FIFO, then
// presents the flit downstream with valid/ready, allowing bounded bursts per grant.
module noc_output_arbiter #(
  parameter int unsigned NUM_IN    = 5,
  parameter int unsigned DATA_W    = noc_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*DATA_W-1:0] fifo_data,
  output logic [NUM_IN-1:0]        fifo_rd,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  input  logic                     out_ready,
  output logic [2:0]               grant
);
  import noc_pkg::*;

  arb_state_e          state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          grant_q, grant_d;
  logic [3:0]          burst_q, burst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [NUM_IN-1:0]   rd_q, rd_d;
  logic [2:0]          pick_idx;
  logic                pick_any;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (3)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    burst_d = burst_q;
    data_d  = data_q;
    valid_d = valid_q;
    rd_d    = '0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = StRd;
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        // The FIFO updated its registered head on the RD edge, so it is stable here.
        data_d  = fifo_data[32'(grant_q) * DATA_W +: DATA_W];
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (req[grant_q] && (burst_q < 4'(MAX_BURST - 1))) begin
            burst_d = burst_q + 4'd1;
            state_d = StRd;
          end else begin
            ptr_d   = grant_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Strobe is registered, so it is driven for exactly the cycle spent in RD.
    if (state_d == StRd) begin
      rd_d[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'(NUM_IN - 1);
      grant_q <= '0;
      burst_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  assign fifo_rd   = rd_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant     = grant_q;

endmodule
